// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared constants and types for the fifo_reader slice.
//   DEF_DATA_WIDTH / DEF_PACK : default FIFO word width and words per beat
//   BEAT_WIDTH, CNT_WIDTH, QCNT_WIDTH : derived widths for the defaults
//   beat_t, qcnt_t : beat payload and output-queue occupancy types
//   cnt_width() : width of a 0..pack counter
package fifo_reader_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 2;
  localparam int unsigned DEF_PACK       = 2;
  localparam int unsigned BEAT_WIDTH     = DEF_DATA_WIDTH * DEF_PACK;
  localparam int unsigned CNT_WIDTH      = $clog2(DEF_PACK + 1);
  localparam int unsigned QCNT_WIDTH     = 2;

  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [QCNT_WIDTH-1:0] qcnt_t;

  // Bits needed to count 0..pack inclusive.
  function automatic int unsigned cnt_width(input int unsigned pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read side plus packed-beat valid/ready stream.
//   fifo_dout/fifo_empty/fifo_pop : push/pop FIFO read port
//   out_data/out_valid/out_ready  : wide beat stream
//   flush                         : single-cycle partial-pack drop request
// slave modport is the reader; master modport is its environment.
interface fifo_reader_if #(
  parameter int unsigned DATA_WIDTH = fifo_reader_pkg::DEF_DATA_WIDTH,
  parameter int unsigned PACK       = fifo_reader_pkg::DEF_PACK
);

  logic [DATA_WIDTH-1:0]      fifo_dout;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic [DATA_WIDTH*PACK-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       flush;

  modport slave (
    input  fifo_dout, fifo_empty, out_ready, flush,
    output fifo_pop, out_data, out_valid
  );

  modport master (
    output fifo_dout, fifo_empty, out_ready, flush,
    input  fifo_pop, out_data, out_valid
  );

endinterface

// File: rtl/fifo_reader_beat_queue.sv
// fifo_reader_beat_queue: 2-entry valid/ready queue, head held in a register.
//   clk, reset (async, active low)
//   enq_valid/enq_data : write side; caller only enqueues when a slot is free
//                        or the head leaves on the same edge
//   out_data/out_valid/out_ready : read side, data stable while stalled
//   qcount : registered occupancy 0..2
module fifo_reader_beat_queue
  import fifo_reader_pkg::*;
#(
  parameter int unsigned BEAT_WIDTH = DEF_DATA_WIDTH * DEF_PACK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq_valid,
  input  logic [BEAT_WIDTH-1:0] enq_data,
  output logic [BEAT_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output qcnt_t                 qcount
);

  localparam qcnt_t Q_EMPTY = QCNT_WIDTH'(0);
  localparam qcnt_t Q_ONE   = QCNT_WIDTH'(1);
  localparam qcnt_t Q_FULL  = QCNT_WIDTH'(2);

  logic [BEAT_WIDTH-1:0] e0_q;
  logic [BEAT_WIDTH-1:0] e1_q;
  qcnt_t                 qcount_q;
  logic                  valid_q;
  logic                  deq_c;

  assign deq_c     = valid_q & out_ready;
  assign out_data  = e0_q;
  assign out_valid = valid_q;
  assign qcount    = qcount_q;

  // e0 is always the head; e1 only holds the second beat when full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_q     <= '0;
      e1_q     <= '0;
      qcount_q <= Q_EMPTY;
      valid_q  <= 1'b0;
    end else begin
      case (qcount_q)
        Q_EMPTY: begin
          if (enq_valid) begin
            e0_q     <= enq_data;
            qcount_q <= Q_ONE;
            valid_q  <= 1'b1;
          end
        end
        Q_ONE: begin
          if (deq_c && enq_valid) begin
            e0_q <= enq_data;
          end else if (deq_c) begin
            qcount_q <= Q_EMPTY;
            valid_q  <= 1'b0;
          end else if (enq_valid) begin
            e1_q     <= enq_data;
            qcount_q <= Q_FULL;
          end
        end
        Q_FULL: begin
          if (deq_c) begin
            e0_q <= e1_q;
            if (enq_valid) begin
              e1_q <= enq_data;
            end else begin
              qcount_q <= Q_ONE;
            end
          end
        end
        default: begin
          qcount_q <= qcount_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a push/pop FIFO, packs PACK words per beat (first word
// in the LSBs) and presents beats through a 2-entry output queue.
//   clk, reset (async, active low)
//   io (fifo_reader_if.slave): fifo_dout/fifo_empty/fifo_pop,
//     out_data/out_valid/out_ready, flush
// fifo_pop depends only on registered state and FIFO/flush inputs, never on
// out_ready.
// Build option FIFO_READER_PAD_EN: flush zero-pads and emits a partial pack
// instead of discarding it, holding the request while the queue is full.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK       = DEF_PACK
) (
  input  logic          clk,
  input  logic          reset,
  fifo_reader_if.slave  io
);

  localparam int unsigned        BEAT_W   = DATA_WIDTH * PACK;
  localparam int unsigned        CNT_W    = cnt_width(PACK);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(PACK);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PACK - 1);
  localparam qcnt_t              Q_FULL   = QCNT_WIDTH'(2);

  logic [BEAT_W-1:0] acc_q;
  logic [BEAT_W-1:0] acc_n;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_n;
  qcnt_t             qcount;
  logic              q_free_c;
  logic              held_c;
  logic              pop_c;
  logic              enq_c;
  logic [BEAT_W-1:0] enq_data_c;
  logic              stall_c;
  int unsigned       slot_lo_c;

`ifdef FIFO_READER_PAD_EN
  logic pend_q;
  logic pend_n;
  assign stall_c = pend_q;
`else
  assign stall_c = 1'b0;
`endif

  assign q_free_c  = (qcount < Q_FULL);
  assign held_c    = (cnt_q == CNT_FULL);
  assign slot_lo_c = 32'(cnt_q) * DATA_WIDTH;

  // Pop whenever there is room for the word: a free slot in the accumulator,
  // or a completed beat that will move into the queue on this edge.
  assign pop_c = reset & ~io.fifo_empty & ~io.flush & ~stall_c &
                 ((cnt_q < CNT_FULL) | q_free_c);
  assign io.fifo_pop = pop_c;

  // Accumulator/count update and beat hand-off to the queue.
  always_comb begin
    acc_n      = acc_q;
    cnt_n      = cnt_q;
    enq_c      = 1'b0;
    enq_data_c = acc_q;
`ifdef FIFO_READER_PAD_EN
    pend_n     = pend_q;
`endif
    if (held_c) begin
      // Completed beat waiting for a queue slot; a same-edge pop starts the next pack.
      if (q_free_c) begin
        enq_c = 1'b1;
        acc_n = '0;
        cnt_n = '0;
        if (pop_c) begin
          acc_n[DATA_WIDTH-1:0] = io.fifo_dout;
          cnt_n                 = CNT_W'(1);
        end
      end
    end else if (pop_c) begin
      acc_n[slot_lo_c +: DATA_WIDTH] = io.fifo_dout;
      if (cnt_q == CNT_LAST) begin
        if (q_free_c) begin
          enq_c      = 1'b1;
          enq_data_c = acc_n;
          acc_n      = '0;
          cnt_n      = '0;
        end else begin
          cnt_n = CNT_FULL;
        end
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end
`ifdef FIFO_READER_PAD_EN
    else if (pend_q) begin
      // Unfilled slots are already zero because the accumulator clears per beat.
      if (q_free_c) begin
        enq_c  = 1'b1;
        acc_n  = '0;
        cnt_n  = '0;
        pend_n = 1'b0;
      end
    end else if (io.flush && (cnt_q != '0)) begin
      if (q_free_c) begin
        enq_c = 1'b1;
        acc_n = '0;
        cnt_n = '0;
      end else begin
        pend_n = 1'b1;
      end
    end
`else
    else if (io.flush) begin
      acc_n = '0;
      cnt_n = '0;
    end
`endif
  end

  // Accumulator state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
`ifdef FIFO_READER_PAD_EN
      pend_q <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_n;
      cnt_q  <= cnt_n;
`ifdef FIFO_READER_PAD_EN
      pend_q <= pend_n;
`endif
    end
  end

  fifo_reader_beat_queue #(
    .BEAT_WIDTH (BEAT_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_c),
    .enq_data  (enq_data_c),
    .out_data  (io.out_data),
    .out_valid (io.out_valid),
    .out_ready (io.out_ready),
    .qcount    (qcount)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader (DATA_WIDTH=2, PACK=2) with a
// FIFO model, an expected-beat queue and a monitor that checks accepted beats.
module tb_fifo_reader;

  localparam int unsigned DW = 2;
  localparam int unsigned PK = 2;
  localparam int unsigned BW = DW * PK;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_reader_if #(.DATA_WIDTH(DW), .PACK(PK)) io_if ();

  fifo_reader #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io_if.slave)
  );

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  logic [BW-1:0] exp_q[$];

  // FIFO model: combinational head, advances on a popped edge.
  logic [DW-1:0] fmem [0:63];
  int frd = 0;
  int fwr = 0;
  assign io_if.fifo_dout  = fmem[frd % 64];
  assign io_if.fifo_empty = (frd == fwr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fmem[fwr % 64] = w;
    fwr++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (io_if.fifo_pop) begin
      if (io_if.fifo_empty) begin
        checks++;
        failures++;
        $display("FAIL pop_when_empty @%0t", $time);
      end
      pops <= pops + 1;
      frd  <= frd + 1;
    end
  end

  // Scoreboard monitor: each accepted beat must be the next expected one.
  always @(negedge clk) begin
    if (reset && io_if.out_valid && io_if.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected got=%0h exp=none @%0t", io_if.out_data, $time);
      end else begin
        check("beat_data", 32'(io_if.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  int base;

  initial begin
    io_if.out_ready = 1'b1;
    io_if.flush     = 1'b0;

    // Reset held with data available.
    push(2'd1); push(2'd2); push(2'd3); push(2'd0);
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0011);
    repeat (2) @(negedge clk);
    check("rst_pop",   32'(io_if.fifo_pop),  0);
    check("rst_valid", 32'(io_if.out_valid), 0);
    check("rst_data",  32'(io_if.out_data),  0);

    // Streaming: four back-to-back pops, beats one cycle after each second pop.
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_pop",   32'(io_if.fifo_pop),  1);
      check("stream_valid", 32'(io_if.out_valid), (i == 2) ? 1 : 0);
    end
    @(negedge clk);
    check("stream_pop_end", 32'(io_if.fifo_pop),  0);
    check("stream_valid_2", 32'(io_if.out_valid), 1);
    step(1);

    // Backpressure: 8 words, consumer stalled.
    io_if.out_ready = 1'b0;
    base = pops;
    push(2'd1); push(2'd2); push(2'd3); push(2'd0);
    push(2'd2); push(2'd2); push(2'd1); push(2'd3);
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1101);
    step(10);
    check("bp_pop_count", 32'(pops - base), 6);
    @(negedge clk);
    check("bp_pop_stalled", 32'(io_if.fifo_pop),  0);
    check("bp_head_valid",  32'(io_if.out_valid), 1);
    check("bp_head_data",   32'(io_if.out_data),  32'(4'b1001));
    @(posedge clk); #1 io_if.out_ready = 1'b1;
    @(negedge clk);
    check("bp_no_pop_on_ready", 32'(io_if.fifo_pop), 0);
    step(6);
    check("bp_pop_total", 32'(pops - base), 8);
    check("bp_drained",   32'(exp_q.size()), 0);

    // Flush with an idle accumulator does nothing.
    io_if.flush = 1'b1;
    step(1);
    io_if.flush = 1'b0;
    @(negedge clk);
    check("flush_idle_valid", 32'(io_if.out_valid), 0);
    step(1);

    // Flush with a partial pack (cnt = 1).
    push(2'd3);
    step(1);
    io_if.flush = 1'b1;
    push(2'd1); push(2'd2);
`ifdef FIFO_READER_PAD_EN
    exp_q.push_back(4'b0011);
`endif
    exp_q.push_back(4'b1001);
    @(negedge clk);
    check("flush_pop_blocked", 32'(io_if.fifo_pop), 0);
    @(posedge clk); #1 io_if.flush = 1'b0;
    @(negedge clk);
`ifdef FIFO_READER_PAD_EN
    check("flush_pad_valid", 32'(io_if.out_valid), 1);
    check("flush_pad_data",  32'(io_if.out_data),  32'(4'b0011));
`else
    check("flush_drop_valid", 32'(io_if.out_valid), 0);
`endif
    step(5);
    check("flush_drained", 32'(exp_q.size()), 0);

`ifdef FIFO_READER_PAD_EN
    // Padded flush while the queue is full waits for a free slot.
    io_if.out_ready = 1'b0;
    push(2'd1); push(2'd2); push(2'd3); push(2'd0); push(2'd1);
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1110);
    step(6);
    io_if.flush = 1'b1;
    push(2'd2); push(2'd3);
    step(1);
    io_if.flush = 1'b0;
    @(negedge clk);
    check("pend_pop_stall", 32'(io_if.fifo_pop), 0);
    step(2);
    @(negedge clk);
    check("pend_pop_stall2", 32'(io_if.fifo_pop), 0);
    @(posedge clk); #1 io_if.out_ready = 1'b1;
    step(8);
    check("pend_drained", 32'(exp_q.size()), 0);
`endif

    // Reset mid-pack with one beat queued and cnt = 1.
    io_if.out_ready = 1'b0;
    push(2'd1); push(2'd2); push(2'd3);
    step(4);
    @(negedge clk);
    check("midrst_pre_valid", 32'(io_if.out_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 32'(io_if.out_valid), 0);
    check("midrst_data",  32'(io_if.out_data),  0);
    @(posedge clk); #1;
    reset = 1'b1;
    io_if.out_ready = 1'b1;
    push(2'd2); push(2'd1);
    exp_q.push_back(4'b0110);
    step(6);

    // Bounded wait for any outstanding expected beats.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
